keypad_cmd: RTL

KEYPAD_CMD -- requirements
Module: keypad_cmd

---
 rtl/rpn_pkg.sv | 45 ++++
 rtl/debounce_ctr.sv | 26 ++
 rtl/keypad_cmd.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/rpn_pkg.sv
// Shared types for the RPN calculator front end: command codes, debounce states, key helpers.
`timescale 1ns/1ps
package rpn_pkg;

  typedef enum logic [3:0] {
    PUSH  = 4'b0000,
    POP   = 4'b0001,
    ADD   = 4'b0010,
    SUB   = 4'b0011,
    MUL   = 4'b0100,
    SLL   = 4'b0101,
    SRL   = 4'b0110,
    LT    = 4'b0111,
    AND   = 4'b1000,
    OR    = 4'b1001,
    NOR   = 4'b1010,
    XOR   = 4'b1011,
    SWAP  = 4'b1100,
    RSV13 = 4'b1101,
    RSV14 = 4'b1110,
    RSV15 = 4'b1111
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } db_state_t;

  function automatic logic is_one_hot(input logic [3:0] p);
    return (p != 4'b0000) && ((p & (p - 4'b0001)) == 4'b0000);
  endfunction

  // Bit index of a one-hot pressed vector; KEY3 -> 3 .. KEY0 -> 0.
  function automatic logic [1:0] key_index(input logic [3:0] p);
    logic [1:0] idx;
    idx = 2'd0;
    if (p[1]) idx = 2'd1;
    if (p[2]) idx = 2'd2;
    if (p[3]) idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/debounce_ctr.sv
// Debounce cycle counter with clear, enable and a terminal-count flag at DEBOUNCE_CYCLES-1.
`timescale 1ns/1ps
module debounce_ctr #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

endmodule

// File: rtl/keypad_cmd.sv
// Debounces the four push-buttons and turns each qualified press into a one-deep
// valid/ready command {mode, 3-key} with the operand switches captured alongside.
`timescale 1ns/1ps
module keypad_cmd
  import rpn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic [3:0]  key,
  input  logic [15:0] val,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic [3:0]  cmd_code,
  output logic [15:0] cmd_val,
  output logic        overrun,
  output logic [7:0]  press_count
);

  logic [3:0]  key_s1, key_s2;
  logic [1:0]  mode_s1, mode_s2;
  logic [3:0]  p, cand;
  db_state_t   state, state_next;
  logic        ctr_clear, ctr_en, tc;
  logic        qualify, cand_load;
  logic        qual_q;
  logic [3:0]  qual_code;
  logic [15:0] qual_val;
  logic        accept;

  // Synchronizers reset to all-ones so a held key looks released right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_s1  <= 4'hF;
      key_s2  <= 4'hF;
      mode_s1 <= 2'b11;
      mode_s2 <= 2'b11;
    end else begin
      key_s1  <= key;
      key_s2  <= key_s1;
      mode_s1 <= mode;
      mode_s2 <= mode_s1;
    end
  end

  assign p = ~key_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cand  <= 4'h0;
    end else begin
      state <= state_next;
      if (cand_load) cand <= p;
    end
  end

  always_comb begin
    state_next = state;
    ctr_clear  = 1'b0;
    ctr_en     = 1'b0;
    qualify    = 1'b0;
    cand_load  = 1'b0;
    unique case (state)
      IDLE: begin
        ctr_clear = 1'b1;
        if (is_one_hot(p)) begin
          state_next = PRESS_WAIT;
          cand_load  = 1'b1;
        end
      end
      PRESS_WAIT: begin
        if (p != cand) begin
          state_next = IDLE;
        end else if (tc) begin
          state_next = HELD;
          qualify    = 1'b1;
        end else begin
          ctr_en = 1'b1;
        end
      end
      HELD: begin
        ctr_clear = 1'b1;
        if (p == 4'h0) state_next = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (p != 4'h0) begin
          state_next = HELD;
        end else if (tc) begin
          state_next = IDLE;
        end else begin
          ctr_en = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  debounce_ctr #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_ctr (
    .clk   (clk),
    .rst   (rst),
    .clear (ctr_clear),
    .enable(ctr_en),
    .tc    (tc)
  );

  // Payload is captured in the qualifying cycle and offered to the buffer one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      qual_q    <= 1'b0;
      qual_code <= 4'h0;
      qual_val  <= 16'h0;
    end else begin
      qual_q <= qualify;
      if (qualify) begin
        qual_code <= {mode_s2, ~key_index(cand)};
        qual_val  <= val;
      end
    end
  end

  assign accept = cmd_valid && cmd_ready;

  // One-deep buffer: a new command replaces the old only if the slot is empty or draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid   <= 1'b0;
      cmd_code    <= 4'h0;
      cmd_val     <= 16'h0;
      overrun     <= 1'b0;
      press_count <= 8'h0;
    end else begin
      overrun <= 1'b0;
      if (accept) press_count <= press_count + 8'd1;
      if (qual_q) begin
        if (!cmd_valid || accept) begin
          cmd_valid <= 1'b1;
          cmd_code  <= qual_code;
          cmd_val   <= qual_val;
        end else begin
          overrun <= 1'b1;
        end
      end else if (accept) begin
        cmd_valid <= 1'b0;
      end
    end
  end

endmodule
